// File: rtl/cell_editor.sv
// cell_editor: queues cell toggles and applies each one as a read-modify-write of the board word, only inside the renderer blank window.
// Optional whole-board clear is compiled in with CELL_EDITOR_CLEAR_EN.
module cell_editor #(
    parameter int READ_LATENCY   = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int WORD_SIZE      = 16,
    parameter int LOG_WORD_SIZE  = 4,
    parameter int BOARD_SIZE     = 64,
    parameter int LOG_BOARD_SIZE = 6,
    parameter int LOG_MAX_ADDR   = 8
) (
    input  logic                      clk_130mhz,
    input  logic                      rst_n_in,
    input  logic                      toggle_valid_in,
    output logic                      toggle_ready_out,
    input  logic [LOG_BOARD_SIZE-1:0] toggle_x_in,
    input  logic [LOG_BOARD_SIZE-1:0] toggle_y_in,
    input  logic                      clear_in,
    input  logic                      done_in,
    output logic [LOG_MAX_ADDR-1:0]   addr_out,
    input  logic [WORD_SIZE-1:0]      data_in,
    output logic [WORD_SIZE-1:0]      data_out,
    output logic                      we_out,
    output logic                      busy_out
);
    // state | meaning
    // IDLE  | waiting for a queued toggle (or pending clear) and an open blank window
    // READ  | board word address driven, waiting out the BRAM read latency
    // WRITE | write back the word with the cell bit flipped, pop the queue
    // CLEAR | zero one word per blank-window cycle until the board is empty
    localparam int WORDS_PER_ROW = BOARD_SIZE / WORD_SIZE;
    localparam int PTR_W         = $clog2(FIFO_DEPTH);
    localparam int LAT_W         = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
`ifdef CELL_EDITOR_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    state_t                    state;
    logic [LOG_BOARD_SIZE-1:0] fifo_x [FIFO_DEPTH];
    logic [LOG_BOARD_SIZE-1:0] fifo_y [FIFO_DEPTH];
    logic [PTR_W:0]            wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic                      empty, full, push, pop, flush, clear_pending_nxt;
    logic [LAT_W-1:0]          lat_cnt;
    logic [WORD_SIZE-1:0]      cur_mask;
    logic [LOG_BOARD_SIZE-1:0] head_x, head_y;
    logic [LOG_MAX_ADDR-1:0]   head_addr;
    logic [LOG_WORD_SIZE-1:0]  head_bit;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign head_x    = fifo_x[rd_ptr[PTR_W-1:0]];
    assign head_y    = fifo_y[rd_ptr[PTR_W-1:0]];
    assign head_addr = (LOG_MAX_ADDR'(head_y) * LOG_MAX_ADDR'(WORDS_PER_ROW)) +
                       LOG_MAX_ADDR'(head_x >> LOG_WORD_SIZE);
    assign head_bit  = LOG_WORD_SIZE'(WORD_SIZE - 1) - head_x[LOG_WORD_SIZE-1:0];

`ifdef CELL_EDITOR_CLEAR_EN
    localparam int NUM_WORDS = BOARD_SIZE * BOARD_SIZE / WORD_SIZE;
    logic                    clear_pending;
    logic                    clr_last;
    logic [LOG_MAX_ADDR-1:0] clr_cnt;

    assign flush             = clear_in && (state != CLEAR);
    assign clr_last          = (state == CLEAR) && done_in &&
                               (clr_cnt == LOG_MAX_ADDR'(NUM_WORDS - 1));
    assign clear_pending_nxt = flush || (clear_pending && !clr_last);
    assign toggle_ready_out  = !full && (state != CLEAR) && !clear_pending;
`else
    logic unused_clear;
    assign unused_clear      = clear_in;
    assign flush             = 1'b0;
    assign clear_pending_nxt = 1'b0;
    assign toggle_ready_out  = !full;
`endif

    assign push = toggle_valid_in && toggle_ready_out;
    // A clear issued mid-RMW has already emptied the queue, so WRITE must not pop.
    assign pop  = (state == WRITE) && !empty;

    always_comb begin
        wr_nxt = wr_ptr;
        rd_nxt = rd_ptr;
        if (flush) begin
            rd_nxt = wr_ptr;
        end else begin
            if (push) wr_nxt = wr_ptr + (PTR_W + 1)'(1);
            if (pop)  rd_nxt = rd_ptr + (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk_130mhz) begin
        if (push) begin
            fifo_x[wr_ptr[PTR_W-1:0]] <= toggle_x_in;
            fifo_y[wr_ptr[PTR_W-1:0]] <= toggle_y_in;
        end
    end

    always_ff @(posedge clk_130mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lat_cnt  <= '0;
            cur_mask <= '0;
            addr_out <= '0;
            data_out <= '0;
            we_out   <= 1'b0;
            busy_out <= 1'b0;
`ifdef CELL_EDITOR_CLEAR_EN
            clear_pending <= 1'b0;
            clr_cnt       <= '0;
`endif
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            busy_out <= (wr_nxt != rd_nxt) || (state == READ) || clear_pending_nxt;
            we_out   <= 1'b0;
`ifdef CELL_EDITOR_CLEAR_EN
            clear_pending <= clear_pending_nxt;
`endif
            case (state)
                IDLE: begin
`ifdef CELL_EDITOR_CLEAR_EN
                    if (clear_pending && done_in) begin
                        state <= CLEAR;
                    end else
`endif
                    if (!empty && done_in) begin
                        state    <= READ;
                        addr_out <= head_addr;
                        cur_mask <= WORD_SIZE'(1) << head_bit;
                        lat_cnt  <= LAT_W'(READ_LATENCY - 1);
                    end
                end
                READ: begin
                    if (lat_cnt == '0) state <= WRITE;
                    else               lat_cnt <= lat_cnt - LAT_W'(1);
                end
                WRITE: begin
                    data_out <= data_in ^ cur_mask;
                    we_out   <= 1'b1;
                    state    <= IDLE;
                end
`ifdef CELL_EDITOR_CLEAR_EN
                CLEAR: begin
                    if (done_in) begin
                        addr_out <= clr_cnt;
                        data_out <= '0;
                        we_out   <= 1'b1;
                        clr_cnt  <= clr_cnt + LOG_MAX_ADDR'(1);
                        if (clr_last) state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule
